hack_cpu_hs: RTL and testbench
==============================

Name: hack_cpu_hs

Overview:
- Parametrised successor to the team's fixed two-phase Hack core.
- The fixed alternate-cycle stall is replaced by ready/valid handshakes on the instruction and data ports, so ROM/RAM/MMIO may take any number of cycles to respond.
- Adds width parameters, read-modify-write sequencing for M, and halt detection.
- Sits between the instruction ROM and the data bus/MMIO decoder at the top of the CPU subsystem.

Parameters:
- DATA_W, 16, datapath/instruction width; minimum 16.
- ADDR_W, 15, instruction and data address width; at most DATA_W-1.
- RESET_PC, 0, PC value loaded at reset.

Ports:
- clk  in  1  clock
- resetN  in  1  reset; asynchronous, active-low
- inst_req  out  1  instruction fetch request
- inst_addr  out  ADDR_W  fetch address; equals PC
- inst  in  DATA_W  instruction word; sampled when inst_req && inst_valid
- inst_valid  in  1  instruction response valid
- data_req  out  1  data access request
- data_we  out  1  1 = write, 0 = read; valid while data_req=1
- data_addr  out  ADDR_W  A[ADDR_W-1:0]
- out_m  out  DATA_W  write data; equals ALU result
- in_m  in  DATA_W  read data; sampled when data_req && !data_we && data_ready
- data_ready  in  1  data access complete
- halted  out  1  core stopped on a self-jump

Behaviour:
- Registers: PC (ADDR_W), A (DATA_W), D (DATA_W), IR (DATA_W), MR (DATA_W), state.
- Reset: PC=RESET_PC, A=0, D=0, IR=0, MR=0, state=IDLE, halted=0, all request outputs 0.
  - Reset asserted mid-access aborts it immediately; no write completes after resetN falls.
- Decode:
  - Bit DATA_W-1 = 0 is an A-instruction: A <= zero-extended inst[DATA_W-2:0].
  - Otherwise a C-instruction with fields a=inst[12], zx..no=inst[11:6], dest A/D/M=inst[5:3], jump lt/eq/gt=inst[2:0].
  - Bits [DATA_W-2:13] of a C-instruction are ignored.
- ALU: combinational, DATA_W wide. x=D; y = a ? MR : A.
  - Standard Hack zx/nx/zy/ny/f(1=add, 0=and)/no; addition wraps modulo 2^DATA_W.
  - Flags: lt=out[DATA_W-1], zr=(out==0), gt=!lt&&!zr.
  - take = C-inst && ((j2&&lt) || (j1&&zr) || (j0&&gt)).
- State machine:
  - IDLE: one cycle after reset release, then FETCH.
  - FETCH: inst_req=1, inst_addr=PC, both held stable until inst_valid. On valid: IR<=inst; go to MEM_RD if C-inst with a=1, else EXEC.
  - MEM_RD: data_req=1, data_we=0, data_addr=A. On data_ready: MR<=in_m, go to EXEC.
  - EXEC: if C-inst with dest M, go to MEM_WR with no commit this cycle. Otherwise commit and go to FETCH (or HALT).
  - MEM_WR: data_req=1, data_we=1, data_addr=A (old A), out_m=ALU out. On data_ready: commit, then FETCH (or HALT).
  - HALT: halted=1, no requests; left only by reset.
- Commit, applied in a single clock edge:
  - A-inst: A <= immediate, PC <= PC+1.
  - C-inst: A <= ALU if dest A; D <= ALU if dest D; PC <= take ? A[ADDR_W-1:0] (old A) : PC+1.
  - A, D and MR stay constant from decode to commit, so the ALU result is stable across MEM_WR wait cycles.
- Halt detection: at commit, if take && A[ADDR_W-1:0]==PC, commit and enter HALT instead of FETCH.
- PC wraps from 2^ADDR_W-1 to 0.
- inst_valid/data_ready are ignored when the matching request is low.
- Minimum latency with zero-wait responses (valid/ready in the request cycle):
  - A-inst or C-inst without M: 2 cycles.
  - C-inst reading M: 3 cycles.
  - C-inst writing M: 3 cycles.
  - M read-modify-write: 4 cycles.

Optional Feature:
- Macro HACK_CPU_STEP_EN.
- Defined:
  - Adds input port step (1 bit) and state PAUSE.
  - Every commit that does not halt goes to PAUSE instead of FETCH.
  - PAUSE leaves to FETCH on the first cycle step=1; step is level-sampled, one instruction per cycle it is high.
  - In PAUSE no requests are issued and halted=0.
- Undefined: no step port, no PAUSE state; the core runs continuously.

Test Plan:
- Zero-wait responses, program "@5; D=A; @7; M=D": sequence is IDLE, then A-inst, A-inst and C-inst at 2 cycles each, then the M write at 3 cycles. Final M write has data_addr=7, out_m=5, data_we=1; D=5, PC=4.
- data_ready delayed 3 cycles on "M=M+1" with A=100, mem[100]=41:
  - MEM_RD holds data_addr=100 for 4 cycles.
  - MEM_WR writes 42 to 100.
  - data_addr, out_m and data_we stay stable for every wait cycle.
- "AM=M-1" with A=10, mem[10]=3: write goes to address 10 with data 2, then A=2.
- Jumps with D=-1 (0xFFFF), A=20:
  - "D;JLT" gives PC=20.
  - "D;JGE" gives PC=PC+1.
  - D=0 with "D;JEQ" gives PC=20.
- "@6; 0;JMP" located at address 6: halted=1 after commit, no further inst_req.
- resetN dropped while in MEM_WR with data_ready low: data_req falls immediately, then PC=RESET_PC, A=D=0, and fetch restarts at RESET_PC after IDLE.

Source files
------------

// File: rtl/hack_cpu_hs.sv
// Hack CPU core with ready/valid instruction and data ports, M read-modify-write and halt-on-self-jump.
// Define HACK_CPU_STEP_EN to add a step input that releases one instruction per cycle it is high.
module hack_cpu_hs #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 15,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              resetN,
`ifdef HACK_CPU_STEP_EN
    input  logic              step,
`endif
    output logic              inst_req,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic [DATA_W-1:0] inst,
    input  logic              inst_valid,
    output logic              data_req,
    output logic              data_we,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] out_m,
    input  logic [DATA_W-1:0] in_m,
    input  logic              data_ready,
    output logic              halted
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        MEM_RD,
        EXEC,
        MEM_WR,
`ifdef HACK_CPU_STEP_EN
        PAUSE,
`endif
        HALT
    } state_t;

`ifdef HACK_CPU_STEP_EN
    localparam state_t RESUME = PAUSE;
`else
    localparam state_t RESUME = FETCH;
`endif

    localparam logic signed [DATA_W-1:0] ZERO = '0;

    state_t                   state_q, state_nx;
    logic        [ADDR_W-1:0] pc_q;
    logic        [DATA_W-1:0] a_q, d_q, ir_q, mr_q;
    logic                     load_ir, load_mr, commit;
    logic                     is_c, dest_a, dest_d, dest_m;
    logic signed [DATA_W-1:0] alu_out;
    logic                     lt, zr, gt, take, halt_hit;

    function automatic logic [DATA_W-1:0] hack_alu(input logic [DATA_W-1:0] x,
                                                   input logic [DATA_W-1:0] y,
                                                   input logic [5:0]        ctl);
        logic [DATA_W-1:0] xs, ys, r;
        xs = ctl[5] ? '0 : x;
        if (ctl[4]) xs = ~xs;
        ys = ctl[3] ? '0 : y;
        if (ctl[2]) ys = ~ys;
        r = ctl[1] ? (xs + ys) : (xs & ys);
        if (ctl[0]) r = ~r;
        return r;
    endfunction

    assign is_c   = ir_q[DATA_W-1];
    assign dest_a = is_c && ir_q[5];
    assign dest_d = is_c && ir_q[4];
    assign dest_m = is_c && ir_q[3];

    // A, D and MR are frozen between decode and commit, so this stays valid through MEM_WR waits
    assign alu_out  = hack_alu(d_q, ir_q[12] ? mr_q : a_q, ir_q[11:6]);
    assign lt       = (alu_out < ZERO);
    assign zr       = (alu_out == ZERO);
    assign gt       = !lt && !zr;
    assign take     = is_c && ((ir_q[2] && lt) || (ir_q[1] && zr) || (ir_q[0] && gt));
    assign halt_hit = take && (a_q[ADDR_W-1:0] == pc_q);

    assign inst_req  = (state_q == FETCH);
    assign inst_addr = pc_q;
    assign data_req  = (state_q == MEM_RD) || (state_q == MEM_WR);
    assign data_we   = (state_q == MEM_WR);
    assign data_addr = a_q[ADDR_W-1:0];
    assign out_m     = alu_out;
    assign halted    = (state_q == HALT);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) state_q <= IDLE;
        else         state_q <= state_nx;
    end

    always_comb begin
        state_nx = state_q;
        load_ir  = 1'b0;
        load_mr  = 1'b0;
        commit   = 1'b0;
        case (state_q)
            IDLE:   state_nx = FETCH;
            FETCH: begin
                if (inst_valid) begin
                    load_ir  = 1'b1;
                    state_nx = (inst[DATA_W-1] && inst[12]) ? MEM_RD : EXEC;
                end
            end
            MEM_RD: begin
                if (data_ready) begin
                    load_mr  = 1'b1;
                    state_nx = EXEC;
                end
            end
            EXEC: begin
                if (dest_m) begin
                    state_nx = MEM_WR;
                end else begin
                    commit   = 1'b1;
                    state_nx = halt_hit ? HALT : RESUME;
                end
            end
            MEM_WR: begin
                if (data_ready) begin
                    commit   = 1'b1;
                    state_nx = halt_hit ? HALT : RESUME;
                end
            end
`ifdef HACK_CPU_STEP_EN
            PAUSE:  if (step) state_nx = FETCH;
`endif
            HALT:   state_nx = HALT;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pc_q <= RESET_PC;
            a_q  <= '0;
            d_q  <= '0;
            ir_q <= '0;
            mr_q <= '0;
        end else begin
            if (load_ir) ir_q <= inst;
            if (load_mr) mr_q <= in_m;
            if (commit) begin
                if (!is_c) begin
                    a_q  <= {1'b0, ir_q[DATA_W-2:0]};
                    pc_q <= pc_q + 1'b1;
                end else begin
                    if (dest_a) a_q <= alu_out;
                    if (dest_d) d_q <= alu_out;
                    pc_q <= take ? a_q[ADDR_W-1:0] : pc_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_hack_cpu_hs.sv
// Self-checking bench for hack_cpu_hs: table of short programs plus hand-written
// sequences for wait states, halt and reset during a pending write.
module tb_hack_cpu_hs;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        inst_req, data_req, data_we, halted;
    logic [14:0] inst_addr, data_addr;
    logic [15:0] inst = 16'h0, in_m = 16'h0, out_m;
    logic        inst_valid = 1'b0, data_ready = 1'b0;
`ifdef HACK_CPU_STEP_EN
    logic        step = 1'b1;
`endif

    always #5 clk = ~clk;

    hack_cpu_hs dut (
        .clk       (clk),
        .resetN    (resetN),
`ifdef HACK_CPU_STEP_EN
        .step      (step),
`endif
        .inst_req  (inst_req),
        .inst_addr (inst_addr),
        .inst      (inst),
        .inst_valid(inst_valid),
        .data_req  (data_req),
        .data_we   (data_we),
        .data_addr (data_addr),
        .out_m     (out_m),
        .in_m      (in_m),
        .data_ready(data_ready),
        .halted    (halted)
    );

    logic [15:0] rom [0:63];
    logic [15:0] ram [0:127];
    int          inst_lat = 0, data_lat = 0, icnt = 0, dcnt = 0;
    int          wr_cnt = 0, fetch_cnt = 0;
    logic [14:0] wr_addr = '0;
    logic [15:0] wr_data = '0;
    int          n_checks = 0, n_fail = 0;

    // Memory responders: valid/ready rises after the configured number of request cycles
    always @(negedge clk) begin
        if (inst_req) begin
            inst_valid = (icnt >= inst_lat);
            inst       = rom[inst_addr[5:0]];
            icnt++;
        end else begin
            inst_valid = 1'b0;
            icnt       = 0;
        end
        if (data_req) begin
            data_ready = (dcnt >= data_lat);
            in_m       = ram[data_addr[6:0]];
            dcnt++;
        end else begin
            data_ready = 1'b0;
            dcnt       = 0;
        end
    end

    always @(posedge clk) begin
        if (!resetN) begin
            wr_cnt    <= 0;
            fetch_cnt <= 0;
            for (int i = 0; i < 128; i++) ram[i] <= 16'h0;
            ram[100] <= 16'd41;
            ram[10]  <= 16'd3;
            ram[50]  <= 16'h1234;
        end else begin
            if (inst_req && inst_valid) fetch_cnt <= fetch_cnt + 1;
            if (data_req && data_we && data_ready) begin
                ram[data_addr[6:0]] <= out_m;
                wr_cnt  <= wr_cnt + 1;
                wr_addr <= data_addr;
                wr_data <= out_m;
            end
        end
    end

    typedef struct {
        string       name;
        logic [15:0] p0, p1, p2, p3;
        int          n;
        logic [15:0] a, d;
        logic [14:0] pc;
        int          wr;
        logic [14:0] wa;
        logic [15:0] wd;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input string name, input logic [15:0] p0, p1, p2, p3, input int n,
                           input logic [15:0] a, d, input logic [14:0] pc,
                           input int wr, input logic [14:0] wa, input logic [15:0] wd);
        vec_t v;
        v.name = name; v.p0 = p0; v.p1 = p1; v.p2 = p2; v.p3 = p3; v.n = n;
        v.a = a; v.d = d; v.pc = pc; v.wr = wr; v.wa = wa; v.wd = wd;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic load_prog(input logic [15:0] p0, p1, p2, p3);
        for (int i = 0; i < 64; i++) rom[i] = 16'h0;
        rom[0] = p0; rom[1] = p1; rom[2] = p2; rom[3] = p3;
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetN = 1'b0;
        repeat (2) @(negedge clk);
        resetN = 1'b1;
    endtask

    task automatic run_until(input int n, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            #1;
            if (fetch_cnt == n && (inst_req || halted)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ok;
        int          cyc, bad, seen;
        logic [14:0] pc_exp [1:10];

        // Reset state
        for (int i = 0; i < 64; i++) rom[i] = 16'h0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst.inst_req", inst_req, 1'b0);
        chk("rst.data_req", data_req, 1'b0);
        chk("rst.halted",   halted,   1'b0);
        chk("rst.pc",       dut.pc_q, 15'd0);
        chk("rst.a",        dut.a_q,  16'd0);
        chk("rst.d",        dut.d_q,  16'd0);

        //        name      p0       p1       p2       p3       n  A        D        PC   wr addr data
        add_vec("md",     16'h0005, 16'hEC10, 16'h0007, 16'hE308, 4, 16'd7,   16'd5,   15'd4,  1, 15'd7,   16'd5);
        add_vec("jlt",    16'h0014, 16'hEE90, 16'hE304, 16'h0000, 3, 16'd20,  16'hFFFF, 15'd20, 0, 15'd0,  16'd0);
        add_vec("jge",    16'h0014, 16'hEE90, 16'hE303, 16'h0000, 3, 16'd20,  16'hFFFF, 15'd3,  0, 15'd0,  16'd0);
        add_vec("jeq",    16'h0014, 16'hEA90, 16'hE302, 16'h0000, 3, 16'd20,  16'd0,   15'd20, 0, 15'd0,   16'd0);
        add_vec("mpp",    16'h0064, 16'hFDC8, 16'h0000, 16'h0000, 2, 16'd100, 16'd0,   15'd2,  1, 15'd100, 16'd42);
        add_vec("amdec",  16'h000A, 16'hFCA8, 16'h0000, 16'h0000, 2, 16'd2,   16'd0,   15'd2,  1, 15'd10,  16'd2);
        add_vec("dsuba",  16'h0003, 16'hEC10, 16'h0005, 16'hE4D0, 4, 16'd5,   16'hFFFE, 15'd4, 0, 15'd0,   16'd0);
        add_vec("dora",   16'h000C, 16'hEC10, 16'h000A, 16'hE550, 4, 16'd10,  16'd14,  15'd4,  0, 15'd0,   16'd0);
        add_vec("ainc",   16'h0007, 16'hEC10, 16'hE7E0, 16'h0000, 3, 16'd8,   16'd7,   15'd3,  0, 15'd0,   16'd0);
        add_vec("wrap",   16'hEE90, 16'h0001, 16'hE090, 16'h0000, 3, 16'd1,   16'd0,   15'd3,  0, 15'd0,   16'd0);
        add_vec("maxi",   16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 1, 16'h7FFF, 16'd0,  15'd1,  0, 15'd0,   16'd0);
        add_vec("jltn",   16'h0014, 16'hEA90, 16'hE304, 16'h0000, 3, 16'd20,  16'd0,   15'd3,  0, 15'd0,   16'd0);
        add_vec("jgt",    16'h0014, 16'hEC10, 16'hE301, 16'h0000, 3, 16'd20,  16'd20,  15'd20, 0, 15'd0,   16'd0);
        add_vec("dm",     16'h0032, 16'hFC10, 16'h0000, 16'h0000, 2, 16'd50,  16'h1234, 15'd2, 0, 15'd0,   16'd0);

        foreach (vecs[i]) begin
            load_prog(vecs[i].p0, vecs[i].p1, vecs[i].p2, vecs[i].p3);
            do_reset();
            run_until(vecs[i].n, ok);
            chk({vecs[i].name, ".done"},   32'(ok),     32'd1);
            chk({vecs[i].name, ".a"},      dut.a_q,     vecs[i].a);
            chk({vecs[i].name, ".d"},      dut.d_q,     vecs[i].d);
            chk({vecs[i].name, ".pc"},     dut.pc_q,    vecs[i].pc);
            chk({vecs[i].name, ".wrcnt"},  wr_cnt,      vecs[i].wr);
            chk({vecs[i].name, ".halted"}, halted,      1'b0);
            if (vecs[i].wr > 0) begin
                chk({vecs[i].name, ".waddr"}, wr_addr, vecs[i].wa);
                chk({vecs[i].name, ".wdata"}, wr_data, vecs[i].wd);
            end
        end

        // Zero-wait cycle timing of "@5; D=A; @7; M=D"
        pc_exp = '{15'd0, 15'd0, 15'd1, 15'd1, 15'd2, 15'd2, 15'd3, 15'd3, 15'd3, 15'd4};
        load_prog(16'h0005, 16'hEC10, 16'h0007, 16'hE308);
        do_reset();
        #1;
        chk("lat.idle_req", inst_req, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("lat.pc%0d", k), dut.pc_q, pc_exp[k]);
            if (k == 1) chk("lat.fetch_req", {inst_req, inst_addr}, {1'b1, 15'd0});
            if (k == 9) chk("lat.mwr_bus", {data_req, data_we, data_addr, out_m}, {1'b1, 1'b1, 15'd7, 16'd5});
        end
        chk("lat.wrcnt", wr_cnt, 1);

        // M=M+1 with data_ready three cycles late
        load_prog(16'h0064, 16'hFDC8, 16'h0000, 16'h0000);
        data_lat = 3;
        do_reset();
        cyc = 0;
        while (!data_req && cyc < 50) begin @(posedge clk); #1; cyc++; end
        chk("rmw.rd_start", {data_req, data_we}, {1'b1, 1'b0});
        cyc = 0; bad = 0;
        while (data_req && !data_we && cyc < 50) begin
            if (data_addr !== 15'd100) bad++;
            cyc++;
            @(posedge clk); #1;
        end
        chk("rmw.rd_cycles", cyc, 4);
        chk("rmw.rd_unstable", bad, 0);
        cyc = 0;
        while (!(data_req && data_we) && cyc < 50) begin @(posedge clk); #1; cyc++; end
        cyc = 0; bad = 0;
        while (data_req && cyc < 50) begin
            if (data_addr !== 15'd100 || out_m !== 16'd42 || data_we !== 1'b1) bad++;
            cyc++;
            @(posedge clk); #1;
        end
        chk("rmw.wr_cycles", cyc, 4);
        chk("rmw.wr_unstable", bad, 0);
        chk("rmw.write", {wr_cnt[7:0], wr_addr, wr_data}, {8'd1, 15'd100, 16'd42});
        chk("rmw.pc", dut.pc_q, 15'd2);
        data_lat = 0;

        // Self-jump at address 6 halts the core
        for (int i = 0; i < 64; i++) rom[i] = 16'h0;
        rom[0] = 16'h0005; rom[1] = 16'hEA87; rom[5] = 16'h0006; rom[6] = 16'hEA87;
        do_reset();
        run_until(4, ok);
        chk("halt.done", 32'(ok), 32'd1);
        chk("halt.halted", halted, 1'b1);
        chk("halt.pc", dut.pc_q, 15'd6);
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); #1;
            if (inst_req || data_req || !halted) seen++;
        end
        chk("halt.quiet", seen, 0);

        // Reset asserted while a write waits for data_ready
        load_prog(16'h0007, 16'hE308, 16'h0000, 16'h0000);
        data_lat = 1000;
        do_reset();
        cyc = 0;
        while (!(data_req && data_we) && cyc < 50) begin @(posedge clk); #1; cyc++; end
        chk("abort.in_mwr", {data_req, data_we}, {1'b1, 1'b1});
        #2;
        resetN = 1'b0;
        #1;
        chk("abort.req_drop", {data_req, data_we}, {1'b0, 1'b0});
        repeat (2) @(posedge clk);
        #1;
        chk("abort.regs", {dut.pc_q, dut.a_q, dut.d_q}, {15'd0, 16'd0, 16'd0});
        chk("abort.nowrite", wr_cnt, 0);
        data_lat = 0;
        @(negedge clk);
        resetN = 1'b1;
        #1;
        chk("abort.idle", inst_req, 1'b0);
        @(posedge clk);
        #1;
        chk("abort.refetch", {inst_req, inst_addr}, {1'b1, 15'd0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
